// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation modes, FSM states
// and the mode classification used when a start request is accepted.
package usr_pkg;

    typedef enum logic [2:0] {
        LOAD = 3'd0,
        SHL  = 3'd1,
        SHR  = 3'd2,
        ROL  = 3'd3,
        ROR  = 3'd4,
        ASR  = 3'd5
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Codes 6 and 7 are reserved and fall outside every enumerated mode.
    function automatic logic is_shift_mode(input mode_t m);
        return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR) || (m == ASR);
    endfunction

endpackage

// File: rtl/usr_step.sv
// One single-position shift/rotate step: next register value and the bit that
// leaves the register.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_value,
    input  mode_t            i_mode,
    input  logic             i_ser_in,
    output logic [WIDTH-1:0] o_value,
    output logic             o_ser_bit
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        o_value   = i_value;
        o_ser_bit = 1'b0;
        case (i_mode)
            SHL: begin
                o_value   = {i_value[WIDTH-2:0], i_ser_in};
                o_ser_bit = i_value[WIDTH-1];
            end
            SHR: begin
                o_value   = {i_ser_in, i_value[WIDTH-1:1]};
                o_ser_bit = i_value[0];
            end
            ROL: begin
                o_value   = {i_value[WIDTH-2:0], i_value[WIDTH-1]};
                o_ser_bit = i_value[WIDTH-1];
            end
            ROR: begin
                o_value   = {i_value[0], i_value[WIDTH-1:1]};
                o_ser_bit = i_value[0];
            end
            ASR: begin
                o_value   = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
                o_ser_bit = i_value[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus multi-cycle shift/rotate by a
// saturated amount, one position per clock, with busy/done handshake.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_next_state;
    mode_t            r_mode;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_data;
    logic             r_ser_out;

    mode_t            w_mode_in;
    logic             w_shift_req;
    logic [CNT_W-1:0] w_count_sat;
    logic [WIDTH-1:0] w_step_value;
    logic             w_step_bit;

    assign w_mode_in   = mode_t'(mode);
    assign w_shift_req = is_shift_mode(w_mode_in) && (amount != '0);
    assign w_count_sat = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;

    usr_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_value  (r_data),
        .i_mode   (r_mode),
        .i_ser_in (ser_in),
        .o_value  (w_step_value),
        .o_ser_bit(w_step_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = w_shift_req ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (r_count == CNT_W'(1)) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == SHIFT);
        done = (r_state == DONE);
    end

    // Mode and count are captured only on acceptance, so input changes while
    // shifting cannot disturb the running operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data    <= '0;
            r_count   <= '0;
            r_mode    <= LOAD;
            r_ser_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_mode_in == LOAD) begin
                            r_data <= data_in;
                        end else if (w_shift_req) begin
                            r_mode  <= w_mode_in;
                            r_count <= w_count_sat;
                        end
                    end
                end
                SHIFT: begin
                    r_data    <= w_step_value;
                    r_ser_out <= w_step_bit;
                    r_count   <= r_count - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign data_out = r_data;
    assign ser_out  = r_ser_out;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=8 with hand-computed expectations.
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] data_in;
    logic             ser_in;
    logic [WIDTH-1:0] data_out;
    logic             ser_out;
    logic             busy;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;
    int nb;
    int nd;
    int leak;

    always #5 clk = ~clk;

    univ_shift_reg #(
        .WIDTH(WIDTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .amount  (amount),
        .data_in (data_in),
        .ser_in  (ser_in),
        .data_out(data_out),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one start, then follows the operation to its done pulse and one
    // cycle beyond, counting busy and done cycles. ser_seq[i] feeds shift step i.
    // With poke set, start is held high with conflicting inputs throughout.
    task automatic run_op(input logic [2:0] m, input logic [CNT_W-1:0] amt,
                          input logic [WIDTH-1:0] din, input logic [15:0] ser_seq,
                          input bit poke, output int n_busy, output int n_done);
        n_busy  = 0;
        n_done  = 0;
        mode    = m;
        amount  = amt;
        data_in = din;
        ser_in  = ser_seq[0];
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                n_done++;
                break;
            end
            if (busy) begin
                ser_in = ser_seq[n_busy & 15];
                n_busy++;
            end
            if (poke) begin
                start   = 1'b1;
                mode    = 3'd0;
                amount  = '0;
                data_in = '1;
            end
            tick();
        end
        tick();
        start = 1'b0;
        if (done) n_done++;
        if (busy) n_busy++;
        ser_in = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        mode    = 3'd0;
        amount  = '0;
        data_in = '0;
        ser_in  = 1'b0;
        #2;
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_ser", 32'(ser_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Parallel load completes in one cycle with no busy phase.
        mode    = 3'd0;
        data_in = 8'hA5;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        data_in = '0;
        check("load_data", 32'(data_out), 32'hA5);
        check("load_done", 32'(done), 32'h1);
        check("load_busy", 32'(busy), 32'h0);
        tick();
        check("load_done_clr", 32'(done), 32'h0);
        check("load_ser_hold", 32'(ser_out), 32'h0);

        run_op(3'd2, 4'd3, 8'h00, 16'h0000, 1'b0, nb, nd);
        check("shr_busy", 32'(nb), 32'd3);
        check("shr_done", 32'(nd), 32'd1);
        check("shr_data", 32'(data_out), 32'h14);
        check("shr_ser", 32'(ser_out), 32'h1);

        run_op(3'd0, 4'd0, 8'h90, 16'h0000, 1'b0, nb, nd);
        check("ld90_busy", 32'(nb), 32'd0);
        check("ld90_data", 32'(data_out), 32'h90);
        check("ld90_ser_hold", 32'(ser_out), 32'h1);

        run_op(3'd5, 4'd2, 8'h00, 16'h0000, 1'b0, nb, nd);
        check("asr_busy", 32'(nb), 32'd2);
        check("asr_data", 32'(data_out), 32'hE4);
        check("asr_ser", 32'(ser_out), 32'h0);

        run_op(3'd0, 4'd0, 8'h81, 16'h0000, 1'b0, nb, nd);
        run_op(3'd3, 4'd12, 8'h00, 16'h0000, 1'b0, nb, nd);
        check("rol_sat_busy", 32'(nb), 32'd8);
        check("rol_sat_done", 32'(nd), 32'd1);
        check("rol_sat_data", 32'(data_out), 32'h81);
        check("rol_sat_ser", 32'(ser_out), 32'h1);

        run_op(3'd4, 4'd3, 8'h00, 16'h0000, 1'b0, nb, nd);
        check("ror_busy", 32'(nb), 32'd3);
        check("ror_data", 32'(data_out), 32'h30);
        check("ror_ser", 32'(ser_out), 32'h0);

        // ser_in sequence 1,0,1,1 with start pulses throughout the operation.
        run_op(3'd0, 4'd0, 8'h00, 16'h0000, 1'b0, nb, nd);
        run_op(3'd1, 4'd4, 8'h00, 16'h000D, 1'b1, nb, nd);
        check("shl_busy", 32'(nb), 32'd4);
        check("shl_done", 32'(nd), 32'd1);
        check("shl_data", 32'(data_out), 32'h0B);
        check("shl_ser", 32'(ser_out), 32'h0);

        run_op(3'd2, 4'd0, 8'hFF, 16'h0000, 1'b0, nb, nd);
        check("amt0_busy", 32'(nb), 32'd0);
        check("amt0_done", 32'(nd), 32'd1);
        check("amt0_data", 32'(data_out), 32'h0B);

        run_op(3'd6, 4'd3, 8'hFF, 16'h0000, 1'b0, nb, nd);
        check("rsvd_busy", 32'(nb), 32'd0);
        check("rsvd_done", 32'(nd), 32'd1);
        check("rsvd_data", 32'(data_out), 32'h0B);

        // Abort SHR 5 after two steps with an asynchronous reset.
        run_op(3'd0, 4'd0, 8'hFF, 16'h0000, 1'b0, nb, nd);
        mode   = 3'd2;
        amount = 4'd5;
        ser_in = 1'b0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("mid_data", 32'(data_out), 32'h3F);
        check("mid_ser", 32'(ser_out), 32'h1);
        check("mid_busy", 32'(busy), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_data", 32'(data_out), 32'h00);
        check("abort_ser", 32'(ser_out), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        leak  = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy) leak++;
            tick();
        end
        check("abort_no_done", 32'(leak), 32'd0);

        run_op(3'd0, 4'd0, 8'h3C, 16'h0000, 1'b0, nb, nd);
        check("post_load_done", 32'(nd), 32'd1);
        check("post_load_busy", 32'(nb), 32'd0);
        check("post_load_data", 32'(data_out), 32'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (SHALL be >= 2).
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), width of the amount port (derived, not overridden).
REQ-003 Port clk input 1, single clock; all state updates on its rising edge.
REQ-004 Port reset input 1, asynchronous active-high reset.
REQ-005 Port start input 1, operation request, sampled only in IDLE.
REQ-006 Port mode input 3, operation select (mode_t), sampled with start.
REQ-007 Port amount input CNT_W, shift count, sampled with start.
REQ-008 Port data_in input WIDTH, parallel load value, sampled with start.
REQ-009 Port ser_in input 1, serial input bit, sampled live on every shift cycle.
REQ-010 Port data_out output WIDTH, current register contents.
REQ-011 Port ser_out output 1, last bit shifted out, held between shifts.
REQ-012 Port busy output 1, high while state is SHIFT.
REQ-013 Port done output 1, high for exactly one cycle when an operation completes.

Function
REQ-014 Modes SHALL be: LOAD=0, SHL=1, SHR=2, ROL=3, ROR=4, ASR=5; codes 6-7 reserved.
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE; the FSM leaves DONE for IDLE unconditionally after one cycle.
REQ-016 In IDLE with start=1 and mode=LOAD, data_out SHALL take data_in on that edge and the FSM SHALL enter DONE.
REQ-017 In IDLE with start=1 and a reserved mode or amount=0, data_out SHALL be unchanged and the FSM SHALL enter DONE.
REQ-018 In IDLE with start=1, a shift/rotate mode and amount>0, the FSM SHALL latch the mode and the count min(amount, WIDTH), then enter SHIFT without modifying data_out on that edge.
REQ-019 In SHIFT, each edge SHALL perform one single-position step and decrement the count; the step with count=1 SHALL move the FSM to DONE.
REQ-020 An accepted shift of k positions SHALL give busy high for exactly k cycles followed by done high for one cycle.
REQ-021 SHL: the register moves toward the MSB, LSB takes ser_in, ser_out takes the old MSB.
REQ-022 SHR: the register moves toward the LSB, MSB takes ser_in, ser_out takes the old LSB.
REQ-023 ROL/ROR: rotate by one position, old MSB/LSB wraps to the opposite end, and ser_out takes the wrapped bit.
REQ-024 ASR: move toward the LSB, MSB is replicated, ser_out takes the old LSB.
REQ-025 start while busy=1 or done=1 SHALL be ignored with no queuing; mode, amount and data_in changes during SHIFT SHALL have no effect.
REQ-026 amount > WIDTH SHALL saturate to WIDTH, so ROL/ROR by WIDTH restores the original value.
REQ-027 ser_out SHALL change only on shift steps; LOAD, no-op and idle cycles SHALL leave it unchanged.

Reset
REQ-028 reset=1 SHALL immediately force data_out=0, ser_out=0, busy=0, done=0, count=0, state=IDLE, regardless of clk.
REQ-029 A reset asserted mid-SHIFT SHALL abort the operation with no done pulse; the first start after deassertion SHALL be accepted normally.

Structure
REQ-030 Package usr_pkg SHALL hold mode_t (3-bit enum, REQ-014 encodings) and state_t (IDLE/SHIFT/DONE).
REQ-031 Sub-module usr_step (combinational, WIDTH-parameterised) SHALL take the value, mode and ser_in and return the next value and the shifted-out bit.
REQ-032 The FSM, count register and data register SHALL reside in univ_shift_reg.

Verification (WIDTH=8)
REQ-033 Reset: assert reset asynchronously mid-cycle -> data_out=0x00, ser_out=0, busy=0, done=0 immediately.
REQ-034 LOAD: start, mode=LOAD, data_in=0xA5 -> data_out=0xA5 after the edge, done=1 on the next cycle, busy never high.
REQ-035 SHR 3 from 0xA5 with ser_in=0 -> busy high 3 cycles, data_out=0x14, ser_out=1, then a single done pulse.
REQ-036 ASR 2 from 0x90 -> data_out=0xE4; ROL with amount=12 from 0x81 -> busy high 8 cycles, data_out=0x81.
REQ-037 SHL 4 from 0x00 with ser_in toggling 1,0,1,1 -> data_out=0x0B; start pulses during busy -> no extra operation.
REQ-038 Reset after the 2nd step of SHR 5 -> data_out=0x00, no done pulse; a following LOAD 0x3C completes normally.
